// File: rtl/mem_pkg.sv
// Shared load/store command encodings and the responder FSM state type,
// common to the decode stage and the data memory responder.
package mem_pkg;

    localparam logic [1:0] MEM_WORD = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_BYTE = 2'b10;
    localparam logic [1:0] MEM_RSVD = 2'b11;

    localparam logic MEM_WRITE = 1'b1;
    localparam logic MEM_READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Number of bytes touched by an access; 0 for the reserved encoding.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            MEM_WORD: size_bytes = 3'd4;
            MEM_HALF: size_bytes = 3'd2;
            MEM_BYTE: size_bytes = 3'd1;
            default:  size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_mux.sv
// Byte-enable generation and read/write lane steering for one aligned word.
// Lane k is the byte at word base + k. DMEM_BIG_ENDIAN_EN selects big-endian.
module dmem_lane_mux
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_lanes,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_lanes,
    output logic [31:0] rdata
);

`ifdef DMEM_BIG_ENDIAN_EN
    localparam bit BIG_ENDIAN = 1'b1;
`else
    localparam bit BIG_ENDIAN = 1'b0;
`endif

    logic [15:0] half_rd;
    logic [15:0] half_wr;

    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = 32'h0;
        rdata    = 32'h0;
        half_rd  = addr_lo[1] ? rd_lanes[31:16] : rd_lanes[15:0];
        half_wr  = BIG_ENDIAN ? {wdata[7:0], wdata[15:8]} : wdata[15:0];
        case (size)
            MEM_WORD: begin
                byte_en  = 4'b1111;
                wr_lanes = BIG_ENDIAN ? {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]}
                                      : wdata;
                rdata    = BIG_ENDIAN ? {rd_lanes[7:0], rd_lanes[15:8], rd_lanes[23:16], rd_lanes[31:24]}
                                      : rd_lanes;
            end
            MEM_HALF: begin
                byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {half_wr, half_wr};
                rdata    = BIG_ENDIAN ? {16'h0, half_rd[7:0], half_rd[15:8]}
                                      : {16'h0, half_rd};
            end
            MEM_BYTE: begin
                byte_en  = 4'b0001 << addr_lo;
                wr_lanes = {4{wdata[7:0]}};
                rdata    = {24'h0, rd_lanes[{addr_lo, 3'b000} +: 8]};
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: one byte/half/word access at a time with
// WAIT_STATES wait cycles; lane order set by DMEM_BIG_ENDIAN_EN (see dmem_lane_mux).
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_enable,
    input  logic              mem_RW,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              mem_err,
    output logic              mem_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    // Handshake: a request is taken on any edge where mem_enable is high in IDLE;
    // mem_busy then stays high through the response cycle, which carries exactly
    // one of mem_done/mem_err for a single cycle. Inputs are ignored while busy.

    mem_state_t        state, next_state;
    logic [CW-1:0]     cnt;
    logic              req_rw;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [7:0]        mem [DEPTH];

    logic              accept;
    logic              cur_rw;
    logic [1:0]        cur_size;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [AW-1:0]     idx;
    logic [AW-1:0]     base;
    logic [AW:0]       end_addr;
    logic              addr_high;
    logic              req_err;
    logic              commit, do_write, do_read, busy_next;
    logic [3:0]        byte_en;
    logic [31:0]       wr_lanes, rd_lanes, lane_rdata;

    assign accept = (state == IDLE) && mem_enable;

    // With zero wait states the commit edge is the accept edge, so the live
    // inputs stand in for the not-yet-latched request registers.
    assign cur_rw    = (state == IDLE) ? mem_RW    : req_rw;
    assign cur_size  = (state == IDLE) ? mem_size  : req_size;
    assign cur_addr  = (state == IDLE) ? mem_addr  : req_addr;
    assign cur_wdata = (state == IDLE) ? mem_wdata : req_wdata;

    assign idx      = cur_addr[AW-1:0];
    assign base     = {idx[AW-1:2], 2'b00};
    assign end_addr = {1'b0, idx} + (AW+1)'(size_bytes(cur_size));

    generate
        if (ADDR_W > AW) begin : g_high
            assign addr_high = |cur_addr[ADDR_W-1:AW];
        end else begin : g_no_high
            assign addr_high = 1'b0;
        end
    endgenerate

    assign req_err = (cur_size == MEM_RSVD)
                   || ((cur_size == MEM_WORD) && (cur_addr[1:0] != 2'b00))
                   || ((cur_size == MEM_HALF) && cur_addr[0])
                   || addr_high
                   || (end_addr > (AW+1)'(DEPTH));

    assign rd_lanes = {mem[base + AW'(3)], mem[base + AW'(2)], mem[base + AW'(1)], mem[base]};

    dmem_lane_mux u_lane_mux (
        .size     (cur_size),
        .addr_lo  (cur_addr[1:0]),
        .wdata    (cur_wdata),
        .rd_lanes (rd_lanes),
        .byte_en  (byte_en),
        .wr_lanes (wr_lanes),
        .rdata    (lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (mem_enable) next_state = (WAIT_STATES > 0) ? WAIT : RESP;
            WAIT:    if (cnt == '0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        commit    = (state != RESP) && (next_state == RESP);
        do_write  = commit && !reset && !req_err && (cur_rw == MEM_WRITE);
        do_read   = commit && !req_err && (cur_rw == MEM_READ);
        busy_next = (next_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept && (WAIT_STATES > 0)) begin
            cnt <= CW'(WAIT_STATES - 1);
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_rw    <= mem_RW;
            req_size  <= mem_size;
            req_addr  <= mem_addr;
            req_wdata <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_rdata <= 32'h0;
            mem_done  <= 1'b0;
            mem_err   <= 1'b0;
            mem_busy  <= 1'b0;
        end else begin
            mem_rdata <= do_read ? lane_rdata : 32'h0;
            mem_done  <= commit && !req_err;
            mem_err   <= commit && req_err;
            mem_busy  <= busy_next;
        end
    end

    // Byte array is deliberately not reset; only enabled lanes are written.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) mem[base + AW'(k)] <= wr_lanes[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random
// traffic against a byte-array reference model (honours DMEM_BIG_ENDIAN_EN).
module tb_data_mem_responder;

    localparam logic [1:0] SZ_W = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_B = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;
    localparam int         WS   = 2;

`ifdef DMEM_BIG_ENDIAN_EN
    localparam bit BIG = 1'b1;
`else
    localparam bit BIG = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        en = 0, rw = 0;
    logic [1:0]  size = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [31:0] rdata;
    logic        done, err, busy;

    logic        en0 = 0, rw0 = 0;
    logic [1:0]  size0 = 0;
    logic [31:0] addr0 = 0, wdata0 = 0;
    logic [31:0] rdata0;
    logic        done0, err0, busy0;

    data_mem_responder #(.DEPTH(256), .ADDR_W(32), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .mem_enable(en), .mem_RW(rw), .mem_size(size),
        .mem_addr(addr), .mem_wdata(wdata), .mem_rdata(rdata), .mem_done(done),
        .mem_err(err), .mem_busy(busy)
    );

    data_mem_responder #(.DEPTH(256), .ADDR_W(32), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .mem_enable(en0), .mem_RW(rw0), .mem_size(size0),
        .mem_addr(addr0), .mem_wdata(wdata0), .mem_rdata(rdata0), .mem_done(done0),
        .mem_err(err0), .mem_busy(busy0)
    );

    int errors = 0;
    int checks = 0;

    // reference model: plain byte array of the WS=2 instance
    logic [7:0] model_mem [256];

    function automatic int nbytes(input logic [1:0] s);
        case (s)
            SZ_W:    return 4;
            SZ_H:    return 2;
            SZ_B:    return 1;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_err(input logic [1:0] s, input logic [31:0] a);
        if (s == SZ_R) return 1'b1;
        if (a % nbytes(s) != 0) return 1'b1;
        return (longint'(a) + nbytes(s)) > 256;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] s, input logic [31:0] a);
        logic [31:0] v = 0;
        int n = nbytes(s);
        for (int i = 0; i < n; i++) begin
            int pos = BIG ? (n - 1 - i) : i;
            v = v | (32'(model_mem[a + i]) << (8 * pos));
        end
        return v;
    endfunction

    task automatic model_write(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        int n = nbytes(s);
        for (int i = 0; i < n; i++) begin
            int pos = BIG ? (n - 1 - i) : i;
            model_mem[a + i] = 8'(d >> (8 * pos));
        end
    endtask

    // driver: one request, observes the response; lat_o = edges after accept
    // edge until the response shows (-1 on timeout); tail_o = any busy/pulse
    // one cycle after the response
    task automatic do_req(input bit sel, input logic rw_i, input logic [1:0] size_i,
                          input logic [31:0] addr_i, input logic [31:0] wd_i,
                          output logic [31:0] rd_o, output bit done_o, output bit err_o,
                          output int lat_o, output int busy_o, output bit tail_o);
        @(negedge clk);
        if (sel) begin en0 = 1; rw0 = rw_i; size0 = size_i; addr0 = addr_i; wdata0 = wd_i; end
        else     begin en  = 1; rw  = rw_i; size  = size_i; addr  = addr_i; wdata  = wd_i; end
        @(posedge clk); #1;
        if (sel) en0 = 0; else en = 0;
        lat_o = -1; busy_o = 0; done_o = 0; err_o = 0; rd_o = '0;
        for (int k = 0; k < 12; k++) begin
            if (sel ? busy0 : busy) busy_o++;
            if (sel ? (done0 | err0) : (done | err)) begin
                done_o = sel ? done0 : done;
                err_o  = sel ? err0 : err;
                rd_o   = sel ? rdata0 : rdata;
                lat_o  = k;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        tail_o = sel ? (busy0 | done0 | err0) : (busy | done | err);
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0 got=%b exp=0", busy0); end
        reset = 0;
    endtask

    task automatic test_word_rw;
        logic [31:0] rd; bit d, e, t; int lat, bz;
        do_req(0, 1'b1, SZ_W, 32'h10, 32'hDEADBEEF, rd, d, e, lat, bz, t);
        model_write(SZ_W, 32'h10, 32'hDEADBEEF);
        checks++; if (d !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL wr_done got=%b/%b exp=1/0", d, e); end
        checks++; if (lat !== WS) begin errors++; $display("FAIL wr_latency got=%0d exp=%0d", lat, WS); end
        checks++; if (bz !== WS + 1) begin errors++; $display("FAIL wr_busy_cycles got=%0d exp=%0d", bz, WS + 1); end
        checks++; if (t !== 1'b0) begin errors++; $display("FAIL wr_tail got=%b exp=0", t); end
        do_req(0, 1'b0, SZ_W, 32'h10, 32'h0, rd, d, e, lat, bz, t);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_word got=%h exp=deadbeef", rd); end
        checks++; if (d !== 1'b1 || lat !== WS) begin errors++; $display("FAIL rd_done_lat got=%b/%0d exp=1/%0d", d, lat, WS); end
        checks++; if (bz !== WS + 1 || t !== 1'b0) begin errors++; $display("FAIL rd_busy got=%0d/%b exp=%0d/0", bz, t, WS + 1); end
    endtask

    task automatic test_subword;
        logic [31:0] rd; bit d, e, t; int lat, bz;
        do_req(0, 1'b1, SZ_W, 32'h20, 32'h0, rd, d, e, lat, bz, t);
        model_write(SZ_W, 32'h20, 32'h0);
        do_req(0, 1'b1, SZ_B, 32'h21, 32'hFFFF_FFAA, rd, d, e, lat, bz, t);
        model_write(SZ_B, 32'h21, 32'hFFFF_FFAA);
        do_req(0, 1'b1, SZ_H, 32'h22, 32'hFFFF_1234, rd, d, e, lat, bz, t);
        model_write(SZ_H, 32'h22, 32'hFFFF_1234);
        do_req(0, 1'b0, SZ_W, 32'h20, 32'h0, rd, d, e, lat, bz, t);
        checks++; if (rd !== model_read(SZ_W, 32'h20)) begin errors++; $display("FAIL sub_word_rd got=%h exp=%h", rd, model_read(SZ_W, 32'h20)); end
        do_req(0, 1'b0, SZ_B, 32'h21, 32'h0, rd, d, e, lat, bz, t);
        checks++; if (rd !== 32'h0000_00AA) begin errors++; $display("FAIL sub_byte_rd got=%h exp=000000aa", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; bit d, e, t; int lat, bz;
        logic        rw_t [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  sz_t [8] = '{SZ_W, SZ_H, SZ_R, SZ_B, SZ_W, SZ_B, SZ_W, SZ_H};
        logic [31:0] ad_t [8] = '{32'h13, 32'h41, 32'h40, 32'h100, 32'h8000_0000, 32'hFF, 32'hFC, 32'hFE};
        do_req(0, 1'b1, SZ_W, 32'h40, 32'hA5C3_0F96, rd, d, e, lat, bz, t);
        model_write(SZ_W, 32'h40, 32'hA5C3_0F96);
        do_req(0, 1'b1, SZ_W, 32'hFC, 32'h8899_AABB, rd, d, e, lat, bz, t);
        model_write(SZ_W, 32'hFC, 32'h8899_AABB);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] wd = $urandom;
            bit          xe = model_err(sz_t[i], ad_t[i]);
            logic [31:0] xr = (xe || rw_t[i]) ? 32'h0 : model_read(sz_t[i], ad_t[i]);
            do_req(0, rw_t[i], sz_t[i], ad_t[i], wd, rd, d, e, lat, bz, t);
            if (!xe && rw_t[i]) model_write(sz_t[i], ad_t[i], wd);
            checks++;
            if (e !== xe || d !== !xe || rd !== xr || lat !== WS) begin
                errors++;
                $display("FAIL err_case%0d got err=%b done=%b rdata=%h lat=%0d exp err=%b done=%b rdata=%h lat=%0d",
                         i, e, d, rd, lat, xe, !xe, xr, WS);
            end
        end
        do_req(0, 1'b0, SZ_W, 32'h40, 32'h0, rd, d, e, lat, bz, t);
        checks++; if (rd !== model_read(SZ_W, 32'h40)) begin errors++; $display("FAIL err_no_write got=%h exp=%h", rd, model_read(SZ_W, 32'h40)); end
    endtask

    // reset asserted d cycles after accept: d=1 lands in WAIT, d=2 on the commit edge
    task automatic test_reset_wait;
        logic [31:0] rd; bit d, e, t; int lat, bz;
        bit pulse;
        do_req(0, 1'b1, SZ_W, 32'h30, 32'h0BAD_F00D, rd, d, e, lat, bz, t);
        model_write(SZ_W, 32'h30, 32'h0BAD_F00D);
        for (int dly = 1; dly <= 2; dly++) begin
            pulse = 0;
            @(negedge clk);
            en = 1; rw = 1; size = SZ_W; addr = 32'h30; wdata = 32'h5555_5555;
            @(posedge clk); #1;
            en = 0;
            for (int k = 1; k < dly; k++) begin
                @(posedge clk); #1;
                if (done | err) pulse = 1;
            end
            reset = 1;
            @(posedge clk); #1;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstwait%0d_busy got=%b exp=0", dly, busy); end
            if (done | err) pulse = 1;
            reset = 0;
            repeat (5) begin
                @(posedge clk); #1;
                if (done | err) pulse = 1;
            end
            checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL rstwait%0d_pulse got=%b exp=0", dly, pulse); end
            do_req(0, 1'b0, SZ_W, 32'h30, 32'h0, rd, d, e, lat, bz, t);
            checks++; if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL rstwait%0d_data got=%h exp=0badf00d", dly, rd); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; bit d, e, t; int lat, bz;
        bit exp_done;
        @(negedge clk);
        en0 = 1; rw0 = 1; size0 = SZ_W; addr0 = 32'h50; wdata0 = 32'hCAFE_F00D;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            exp_done = (i % 2 == 0);
            checks++;
            if (done0 !== exp_done || err0 !== 1'b0) begin
                errors++;
                $display("FAIL b2b_cycle%0d got done=%b err=%b exp done=%b err=0", i, done0, err0, exp_done);
            end
        end
        en0 = 0;
        repeat (2) @(posedge clk);
        do_req(1, 1'b0, SZ_W, 32'h50, 32'h0, rd, d, e, lat, bz, t);
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_readback got=%h exp=cafef00d", rd); end
        checks++; if (lat !== 0 || bz !== 1 || t !== 1'b0) begin errors++; $display("FAIL b2b_ws0_timing got lat=%0d busy=%0d tail=%b exp 0/1/0", lat, bz, t); end
    endtask

    task automatic test_endian;
        logic [31:0] rd; bit d, e, t; int lat, bz;
        logic [31:0] xb = BIG ? 32'h11 : 32'h44;
        logic [31:0] xh = BIG ? 32'h3344 : 32'h1122;
        do_req(0, 1'b1, SZ_W, 32'h0, 32'h1122_3344, rd, d, e, lat, bz, t);
        model_write(SZ_W, 32'h0, 32'h1122_3344);
        do_req(0, 1'b0, SZ_B, 32'h0, 32'h0, rd, d, e, lat, bz, t);
        checks++; if (rd !== xb) begin errors++; $display("FAIL endian_byte got=%h exp=%h", rd, xb); end
        do_req(0, 1'b0, SZ_H, 32'h2, 32'h0, rd, d, e, lat, bz, t);
        checks++; if (rd !== xh) begin errors++; $display("FAIL endian_half got=%h exp=%h", rd, xh); end
    endtask

    task automatic test_random;
        logic [31:0] rd; bit d, e, t; int lat, bz;
        for (int w = 0; w < 64; w++) begin
            logic [31:0] wd = $urandom;
            do_req(0, 1'b1, SZ_W, 32'(4 * w), wd, rd, d, e, lat, bz, t);
            model_write(SZ_W, 32'(4 * w), wd);
        end
        for (int n = 0; n < 150; n++) begin
            int          r  = $urandom_range(0, 9);
            int          ar = $urandom_range(0, 19);
            logic [1:0]  s  = (r < 3) ? SZ_W : (r < 6) ? SZ_H : (r < 9) ? SZ_B : SZ_R;
            logic        w_ = 1'($urandom_range(0, 1));
            logic [31:0] a  = (ar < 17) ? 32'($urandom_range(0, 255))
                            : (ar < 19) ? 32'($urandom_range(252, 263))
                            : (32'h1 << $urandom_range(8, 31)) | 32'($urandom_range(0, 255));
            logic [31:0] wd = $urandom;
            bit          xe = model_err(s, a);
            logic [31:0] xr = (xe || w_) ? 32'h0 : model_read(s, a);
            do_req(0, w_, s, a, wd, rd, d, e, lat, bz, t);
            if (!xe && w_) model_write(s, a, wd);
            checks++;
            if (e !== xe || d !== !xe || rd !== xr || lat !== WS || t !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d rw=%b size=%b addr=%h got err=%b done=%b rdata=%h lat=%0d exp err=%b done=%b rdata=%h lat=%0d",
                         n, w_, s, a, e, d, rd, lat, xe, !xe, xr, WS);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_subword();
        test_errors();
        test_reset_wait();
        test_back_to_back();
        test_endian();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
